// File: rtl/adc_pkg.sv
// Shared widths, FSM encoding and lane formatting for the ADC sample packer.
package adc_pkg;

    localparam int LANE_W           = 16;
    localparam int SAMPLE_W         = 12;
    localparam int SAMPLES_PER_WORD = 4;
    localparam int WORD_W           = LANE_W * SAMPLES_PER_WORD;
    localparam int LANE_IDX_W       = $clog2(SAMPLES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // The OTR flag rides in the lane MSB so downstream can spot clipped samples.
    function automatic logic [LANE_W-1:0] make_lane(input logic otr,
                                                    input logic [SAMPLE_W-1:0] data);
        return {otr, 3'b000, data};
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Show-ahead synchronous word FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module sync_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_PSRAM,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             valid_r;
    logic             pop_s;
    logic             push_s;

    // Qualify push/pop against occupancy and work out the next count.
    always_comb begin
        pop_s        = pop && (count_r != {CNT_W{1'b0}});
        push_s       = push && ((count_r != CNT_W'(DEPTH)) || pop_s);
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and registered occupancy flags.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CNT_W{1'b0}});
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign valid     = valid_r;
    assign count     = count_r;

endmodule

// File: rtl/adc_sample_packer.sv
// Packs four 12-bit ADC samples per 64-bit word, buffers them and hands them to the
// PSRAM write controller with a linearly incrementing word address.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 21,
    parameter int TOTAL_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk_PSRAM,
    input  logic                  rst_n,
    input  logic                  capture_start,
    input  logic                  adc_ready,
    input  logic [SAMPLE_W-1:0]   adc_data,
    input  logic                  adc_OTR,
    output logic                  adc_enable,
    output logic                  word_valid,
    output logic [WORD_W-1:0]     word_data,
    output logic [ADDR_WIDTH-1:0] word_addr,
    input  logic                  word_ready,
    output logic                  capture_done,
    output logic                  overflow
);

    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL_WORDS - 1);

    state_e                  state_r;
    logic                    in_valid_r;
    logic [LANE_W-1:0]       in_lane_r;
    logic [LANE_IDX_W-1:0]   lane_idx_r;
    logic [3*LANE_W-1:0]     lanes_r;
    logic [WORD_W-1:0]       word_r;
    logic                    push_pending_r;
    logic [CNT_W-1:0]        pushed_cnt_r;
    logic [CNT_W-1:0]        popped_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    adc_enable_r;
    logic                    capture_done_r;
    logic                    overflow_r;

    logic                    fifo_valid_s;
    logic [WORD_W-1:0]       fifo_head_s;
    logic [FCNT_W-1:0]       fifo_count_s;
    logic                    fifo_pop_s;
    logic                    fifo_push_s;
    logic                    push_req_s;
    logic                    push_room_s;

    // A full FIFO still takes a word when the head leaves on the same edge.
    always_comb begin
        fifo_pop_s  = fifo_valid_s && word_ready;
        push_req_s  = push_pending_r && (state_r == CAPTURE);
        push_room_s = (fifo_count_s < FCNT_W'(FIFO_DEPTH)) || fifo_pop_s;
        if (push_req_s && push_room_s) begin
            fifo_push_s = 1'b1;
        end else begin
            fifo_push_s = 1'b0;
        end
    end

    sync_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_PSRAM (clk_PSRAM),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (word_r),
        .pop       (fifo_pop_s),
        .head_data (fifo_head_s),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    // Capture FSM: sample register, lane assembly, word/address counters and outputs.
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            in_valid_r     <= 1'b0;
            in_lane_r      <= {LANE_W{1'b0}};
            lane_idx_r     <= {LANE_IDX_W{1'b0}};
            lanes_r        <= {(3*LANE_W){1'b0}};
            word_r         <= {WORD_W{1'b0}};
            push_pending_r <= 1'b0;
            pushed_cnt_r   <= {CNT_W{1'b0}};
            popped_cnt_r   <= {CNT_W{1'b0}};
            addr_r         <= {ADDR_WIDTH{1'b0}};
            adc_enable_r   <= 1'b0;
            capture_done_r <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            capture_done_r <= 1'b0;
            push_pending_r <= 1'b0;
            in_valid_r     <= adc_ready && (state_r == CAPTURE);
            in_lane_r      <= make_lane(adc_OTR, adc_data);
            if (fifo_pop_s) begin
                addr_r       <= addr_r + ADDR_WIDTH'(1);
                popped_cnt_r <= popped_cnt_r + CNT_W'(1);
            end
            case (state_r)
                IDLE: begin
                    adc_enable_r <= 1'b0;
                    if (capture_start) begin
                        overflow_r   <= 1'b0;
                        lane_idx_r   <= {LANE_IDX_W{1'b0}};
                        pushed_cnt_r <= {CNT_W{1'b0}};
                        popped_cnt_r <= {CNT_W{1'b0}};
                        addr_r       <= {ADDR_WIDTH{1'b0}};
                        adc_enable_r <= 1'b1;
                        state_r      <= CAPTURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (in_valid_r) begin
                        case (lane_idx_r)
                            2'd0:    lanes_r[LANE_W-1:0]          <= in_lane_r;
                            2'd1:    lanes_r[2*LANE_W-1:LANE_W]   <= in_lane_r;
                            2'd2:    lanes_r[3*LANE_W-1:2*LANE_W] <= in_lane_r;
                            default: begin
                                word_r         <= {in_lane_r, lanes_r};
                                push_pending_r <= 1'b1;
                            end
                        endcase
                        lane_idx_r <= lane_idx_r + LANE_IDX_W'(1);
                    end
                    // Dropped words do not count toward the capture length.
                    if (push_req_s) begin
                        if (push_room_s) begin
                            pushed_cnt_r <= pushed_cnt_r + CNT_W'(1);
                            if (pushed_cnt_r == LAST_WORD) begin
                                adc_enable_r <= 1'b0;
                                state_r      <= DRAIN;
                            end else begin
                                state_r <= CAPTURE;
                            end
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    adc_enable_r <= 1'b0;
                    if (fifo_pop_s && (popped_cnt_r == LAST_WORD)) begin
                        capture_done_r <= 1'b1;
                        state_r        <= DONE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    adc_enable_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    adc_enable_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign adc_enable   = adc_enable_r;
    assign word_valid   = fifo_valid_s;
    assign word_data    = fifo_head_s;
    assign word_addr    = addr_r;
    assign capture_done = capture_done_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer: two instances (2-word and 6-word captures)
// share stimulus; a monitor collects accepted words which each test compares in order.
module tb_adc_sample_packer;

    localparam int AW = 21;
    typedef logic [64+AW-1:0] ent_t;

    logic          clk_PSRAM = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture_start = 1'b0;
    logic          adc_ready = 1'b0;
    logic [11:0]   adc_data = 12'h000;
    logic          adc_OTR = 1'b0;
    logic          word_ready = 1'b0;

    logic          a_enable, a_valid, a_done, a_ovf;
    logic [63:0]   a_data;
    logic [AW-1:0] a_addr;
    logic          b_enable, b_valid, b_done, b_ovf;
    logic [63:0]   b_data;
    logic [AW-1:0] b_addr;

    ent_t          exp_q[$];
    ent_t          obs_q[$];
    int            total = 0;
    int            bad = 0;
    int            stall_err = 0;
    int            done_cnt = 0;
    bit            sel_b = 1'b0;
    logic [AW-1:0] exp_addr = '0;

    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data;
    logic [AW-1:0] prev_addr;
    logic          mon_valid, mon_done;
    logic [63:0]   mon_data;
    logic [AW-1:0] mon_addr;

    always #5 clk_PSRAM = ~clk_PSRAM;

    adc_sample_packer #(.ADDR_WIDTH(AW), .TOTAL_WORDS(2), .FIFO_DEPTH(4)) dut_a (
        .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .capture_start(capture_start),
        .adc_ready(adc_ready), .adc_data(adc_data), .adc_OTR(adc_OTR),
        .adc_enable(a_enable), .word_valid(a_valid), .word_data(a_data),
        .word_addr(a_addr), .word_ready(word_ready), .capture_done(a_done),
        .overflow(a_ovf));

    adc_sample_packer #(.ADDR_WIDTH(AW), .TOTAL_WORDS(6), .FIFO_DEPTH(4)) dut_b (
        .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .capture_start(capture_start),
        .adc_ready(adc_ready), .adc_data(adc_data), .adc_OTR(adc_OTR),
        .adc_enable(b_enable), .word_valid(b_valid), .word_data(b_data),
        .word_addr(b_addr), .word_ready(word_ready), .capture_done(b_done),
        .overflow(b_ovf));

    assign mon_valid = sel_b ? b_valid : a_valid;
    assign mon_data  = sel_b ? b_data  : a_data;
    assign mon_addr  = sel_b ? b_addr  : a_addr;
    assign mon_done  = sel_b ? b_done  : a_done;

    // Collect accepted words, count done pulses and flag head changes during stalls.
    always @(negedge clk_PSRAM) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (mon_valid && word_ready) obs_q.push_back({mon_data, mon_addr});
            if (prev_stall && (mon_valid !== 1'b1 || mon_data !== prev_data || mon_addr !== prev_addr))
                stall_err++;
            if (mon_done) done_cnt++;
            prev_stall = mon_valid && !word_ready;
            prev_data  = mon_data;
            prev_addr  = mon_addr;
        end
    end

    function automatic logic [63:0] pack(input logic [11:0] s0, input logic [11:0] s1,
                                         input logic [11:0] s2, input logic [11:0] s3,
                                         input logic [3:0] otr);
        return {otr[3], 3'b000, s3, otr[2], 3'b000, s2, otr[1], 3'b000, s1, otr[0], 3'b000, s0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        capture_start = 1'b0;
        adc_ready = 1'b0;
        repeat (2) @(posedge clk_PSRAM);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_addr = '0;
    endtask

    task automatic start_capture();
        capture_start = 1'b1;
        @(posedge clk_PSRAM);
        #1;
        capture_start = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2,
                             input logic [11:0] s3, input logic [3:0] otr, input bit kept);
        logic [11:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        if (kept) begin
            exp_q.push_back({pack(s0, s1, s2, s3, otr), exp_addr});
            exp_addr = exp_addr + 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            adc_ready = 1'b1;
            adc_data  = s[i];
            adc_OTR   = otr[i];
            @(posedge clk_PSRAM);
            #1;
            adc_ready = 1'b0;
        end
    endtask

    task automatic wait_obs(output bit ok);
        int w;
        w = 0;
        while (obs_q.size() == 0 && w < 300) begin
            @(posedge clk_PSRAM);
            w++;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        do_reset();
        total++;
        if ({a_enable, a_valid, a_data, a_addr, a_done, a_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_a: got en=%b v=%b d=%h a=%h done=%b ovf=%b, want all 0",
                     a_enable, a_valid, a_data, a_addr, a_done, a_ovf);
        end
        total++;
        if ({b_enable, b_valid, b_data, b_addr, b_done, b_ovf} !== '0) begin
            bad++;
            $display("FAIL reset_b: got en=%b v=%b d=%h a=%h done=%b ovf=%b, want all 0",
                     b_enable, b_valid, b_data, b_addr, b_done, b_ovf);
        end
    endtask

    task automatic test_basic();
        bit ok; ent_t got, want; int base;
        sel_b = 1'b0;
        do_reset();
        word_ready = 1'b1;
        base = done_cnt;
        start_capture();
        total++;
        if (a_enable !== 1'b1) begin bad++; $display("FAIL basic_enable_on: got %b want 1", a_enable); end
        send_word(12'h001, 12'h002, 12'h003, 12'h004, 4'b0000, 1'b1);
        send_word(12'h005, 12'h006, 12'h007, 12'h008, 4'b0000, 1'b1);
        repeat (3) @(posedge clk_PSRAM);
        #1;
        total++;
        if (a_enable !== 1'b0) begin bad++; $display("FAIL basic_enable_off: got %b want 0", a_enable); end
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL basic_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL basic_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
        total++;
        if (done_cnt - base !== 1) begin bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - base); end
        total++;
        if (a_ovf !== 1'b0) begin bad++; $display("FAIL basic_overflow: got %b want 0", a_ovf); end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL basic_extra: got %0d extra words want 0", obs_q.size()); end
    endtask

    task automatic test_otr_latency();
        bit ok; ent_t got, want; int base;
        sel_b = 1'b0;
        do_reset();
        word_ready = 1'b0;
        base = done_cnt;
        start_capture();
        send_word(12'h111, 12'h222, 12'hABC, 12'h333, 4'b0100, 1'b1);
        @(posedge clk_PSRAM);
        #1;
        total++;
        if (a_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got valid=%b want 0", a_valid); end
        @(posedge clk_PSRAM);
        #1;
        total++;
        if (a_valid !== 1'b1) begin bad++; $display("FAIL latency_rise: got valid=%b want 1", a_valid); end
        total++;
        if (a_data[47:32] !== 16'h8ABC) begin bad++; $display("FAIL otr_lane2: got %h want 8abc", a_data[47:32]); end
        word_ready = 1'b1;
        send_word(12'hFFF, 12'h000, 12'h7FF, 12'h800, 4'b1001, 1'b1);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL otr_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL otr_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
        total++;
        if (done_cnt - base !== 1) begin bad++; $display("FAIL otr_done: got %0d pulses want 1", done_cnt - base); end
    endtask

    task automatic test_overflow();
        bit ok; ent_t got, want; int base;
        sel_b = 1'b1;
        do_reset();
        word_ready = 1'b0;
        base = done_cnt;
        start_capture();
        for (int w = 0; w < 6; w++) begin
            send_word(12'(16*w + 1), 12'(16*w + 2), 12'(16*w + 3), 12'(16*w + 4), 4'(w), w < 4);
        end
        repeat (3) @(posedge clk_PSRAM);
        #1;
        total++;
        if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", b_ovf); end
        total++;
        if (b_enable !== 1'b1) begin bad++; $display("FAIL ovf_still_capture: got en=%b want 1", b_enable); end
        word_ready = 1'b1;
        send_word(12'h701, 12'h702, 12'h703, 12'h704, 4'b1111, 1'b1);
        send_word(12'h801, 12'h802, 12'h803, 12'h804, 4'b0000, 1'b1);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL ovf_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL ovf_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
        total++;
        if (done_cnt - base !== 1) begin bad++; $display("FAIL ovf_done: got %0d pulses want 1", done_cnt - base); end
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL ovf_extra: got %0d extra words want 0", obs_q.size()); end
    endtask

    task automatic test_full_simul();
        bit ok; ent_t got, want;
        sel_b = 1'b1;
        do_reset();
        word_ready = 1'b0;
        start_capture();
        for (int w = 0; w < 5; w++) begin
            send_word(12'(32*w + 9), 12'(32*w + 10), 12'(32*w + 11), 12'(32*w + 12), 4'b0010, 1'b1);
        end
        @(posedge clk_PSRAM);
        #1;
        word_ready = 1'b1;
        @(posedge clk_PSRAM);
        #1;
        word_ready = 1'b0;
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL full_simul_ovf: got %b want 0", b_ovf); end
        total++;
        if (dut_b.u_fifo.count_r !== 3'd4) begin
            bad++; $display("FAIL full_simul_count: got %0d want 4", dut_b.u_fifo.count_r);
        end
        word_ready = 1'b1;
        send_word(12'hC01, 12'hC02, 12'hC03, 12'hC04, 4'b1000, 1'b1);
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL full_simul_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL full_simul_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
    endtask

    task automatic test_back_to_back();
        bit ok; ent_t got, want; int base_stall; logic [11:0] s [4]; logic [3:0] otr;
        sel_b = 1'b1;
        do_reset();
        base_stall = stall_err;
        start_capture();
        for (int i = 0; i < 24; i++) begin
            s[i % 4]   = 12'(12'h100 + 37 * i);
            otr[i % 4] = (i % 3) == 0;
            if (i % 4 == 3) begin
                exp_q.push_back({pack(s[0], s[1], s[2], s[3], otr), exp_addr});
                exp_addr = exp_addr + 1'b1;
            end
            adc_ready  = 1'b1;
            adc_data   = s[i % 4];
            adc_OTR    = otr[i % 4];
            word_ready = i[0];
            @(posedge clk_PSRAM);
            #1;
        end
        adc_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            word_ready = i[0];
            @(posedge clk_PSRAM);
            #1;
        end
        word_ready = 1'b1;
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL b2b_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL b2b_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
        total++;
        if (b_ovf !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", b_ovf); end
        total++;
        if (stall_err - base_stall !== 0) begin
            bad++; $display("FAIL b2b_stable: got %0d stall changes want 0", stall_err - base_stall);
        end
    endtask

    task automatic test_midreset();
        bit ok; ent_t got, want;
        sel_b = 1'b1;
        do_reset();
        word_ready = 1'b0;
        start_capture();
        send_word(12'hD01, 12'hD02, 12'hD03, 12'hD04, 4'b0000, 1'b0);
        send_word(12'hD05, 12'hD06, 12'hD07, 12'hD08, 4'b0000, 1'b0);
        send_word(12'hD09, 12'hD0A, 12'h000, 12'h000, 4'b0000, 1'b0);
        repeat (3) @(posedge clk_PSRAM);
        #1;
        total++;
        if (b_valid !== 1'b1) begin bad++; $display("FAIL midreset_pre: got valid=%b want 1", b_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({b_valid, b_enable} !== 2'b00) begin
            bad++; $display("FAIL midreset_now: got valid=%b en=%b want 0 0", b_valid, b_enable);
        end
        @(posedge clk_PSRAM);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_addr = '0;
        word_ready = 1'b1;
        start_capture();
        for (int w = 0; w < 6; w++) begin
            send_word(12'(64*w + 5), 12'(64*w + 6), 12'(64*w + 7), 12'(64*w + 8), 4'b0001, 1'b1);
        end
        while (exp_q.size() != 0) begin
            wait_obs(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL midreset_word: got nothing, want %h", exp_q[0]); exp_q.delete();
            end else begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin
                    bad++; $display("FAIL midreset_word: got d=%h a=%0d, want d=%h a=%0d",
                                    got[84:21], got[20:0], want[84:21], want[20:0]);
                end
            end
        end
        repeat (5) @(posedge clk_PSRAM);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_otr_latency();
        test_overflow();
        test_full_simul();
        test_back_to_back();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
